bp_skid_pipe: RTL and testbench

Parametrised pipeline of skid-buffer stages with ready/valid backpressure. Registers both `valid` and `ready` at every stage, so it breaks all forward and backward combinational paths and keeps full throughput of one transfer per cycle. Adds a synchronous flush and an occupancy count. Sits between streaming producers and consumers where long ready paths must be retimed, for example at accelerator datapath boundaries and across floorplan distance.

---
 rtl/bp_skid_pipe.sv | 163 ++++++++++++++++
 tb/tb_bp_skid_pipe.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_skid_pipe.sv
// bp_skid_pipe: PIPES skid stages with registered valid/ready, flush, occupancy count; BP_SKID_PIPE_PERF_EN adds stall_cnt_o.
// Latency: PIPES cycles upstream transfer to valid_o when unstalled; PIPES=0 is a combinational pass-through.
// Backpressure: ready_o is a flop (NOT stage-0 skid valid); up to 2*PIPES items absorbed after ready_i drops.
module bp_skid_pipe #(
    parameter int DATAW = 8,
    parameter int PIPES = 1,
    parameter int CNTW  = (PIPES == 0) ? 1 : $clog2(2*PIPES+1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic [DATAW-1:0] data_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [DATAW-1:0] data_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [CNTW-1:0]  count_o
`ifdef BP_SKID_PIPE_PERF_EN
    ,
    output logic [31:0]      stall_cnt_o
`endif
);

    // Encoding makes bit 0 the main-valid flop and bit 1 the skid-valid flop.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b11
    } stg_state_t;

    if (PIPES == 0) begin : g_pass
        assign data_o  = data_i;
        assign valid_o = valid_i;
        assign ready_o = ready_i;
        assign count_o = '0;
    end else begin : g_pipe
        logic [PIPES-1:0] w_main_vld;
        logic [PIPES-1:0] w_skid_vld;
        logic [DATAW-1:0] w_main_dat [PIPES];
        logic [CNTW-1:0]  w_cnt;

        for (genvar k = 0; k < PIPES; k++) begin : g_stg
            stg_state_t       r_state;
            stg_state_t       w_state_nxt;
            logic [DATAW-1:0] r_main_dat;
            logic [DATAW-1:0] r_skid_dat;
            logic             w_up_vld;
            logic [DATAW-1:0] w_up_dat;
            logic             w_dn_rdy;
            logic             w_in;
            logic             w_out;
            logic             w_ld_main;
            logic             w_ld_skid;
            logic             w_main_from_skid;

            if (k == 0) begin : g_head
                assign w_up_vld = valid_i;
                assign w_up_dat = data_i;
            end else begin : g_body
                assign w_up_vld = w_main_vld[k-1];
                assign w_up_dat = w_main_dat[k-1];
            end

            if (k == PIPES-1) begin : g_tail
                assign w_dn_rdy = ready_i;
            end else begin : g_link
                assign w_dn_rdy = ~w_skid_vld[k+1];
            end

            assign w_in  = w_up_vld & ~r_state[1];
            assign w_out = r_state[0] & w_dn_rdy;

            always_comb begin
                w_state_nxt      = r_state;
                w_ld_main        = 1'b0;
                w_ld_skid        = 1'b0;
                w_main_from_skid = 1'b0;
                unique case (r_state)
                    ST_EMPTY: begin
                        if (w_in) begin
                            w_state_nxt = ST_ONE;
                            w_ld_main   = 1'b1;
                        end
                    end
                    ST_ONE: begin
                        if (w_in && w_out) begin
                            w_ld_main = 1'b1;
                        end else if (w_in) begin
                            w_state_nxt = ST_TWO;
                            w_ld_skid   = 1'b1;
                        end else if (w_out) begin
                            w_state_nxt = ST_EMPTY;
                        end
                    end
                    ST_TWO: begin
                        if (w_out) begin
                            w_state_nxt      = ST_ONE;
                            w_ld_main        = 1'b1;
                            w_main_from_skid = 1'b1;
                        end
                    end
                    default: w_state_nxt = ST_EMPTY;
                endcase
            end

            always_ff @(posedge clk_i) begin
                if (rst_i || flush_i) begin
                    r_state <= ST_EMPTY;
                end else begin
                    r_state <= w_state_nxt;
                end
            end

            // Flush only drops the valid bits; stale payload is never observed.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_main_dat <= '0;
                    r_skid_dat <= '0;
                end else begin
                    if (w_ld_main) begin
                        r_main_dat <= w_main_from_skid ? r_skid_dat : w_up_dat;
                    end
                    if (w_ld_skid) begin
                        r_skid_dat <= w_up_dat;
                    end
                end
            end

            assign w_main_vld[k] = r_state[0];
            assign w_skid_vld[k] = r_state[1];
            assign w_main_dat[k] = r_main_dat;
        end

        always_comb begin
            w_cnt = '0;
            for (int i = 0; i < PIPES; i++) begin
                w_cnt = w_cnt + CNTW'(w_main_vld[i]) + CNTW'(w_skid_vld[i]);
            end
        end

        assign ready_o = ~w_skid_vld[0];
        assign valid_o = w_main_vld[PIPES-1];
        assign data_o  = w_main_dat[PIPES-1];
        assign count_o = w_cnt;
    end

`ifdef BP_SKID_PIPE_PERF_EN
    logic [31:0] r_stall_cnt;

    // Survives flush so stall statistics span the whole run since reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
        end else if (valid_o && !ready_i && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_bp_skid_pipe.sv
// Bench for bp_skid_pipe: three instances (PIPES=3, 2, 0), table vectors, directed corner cases, random scoreboard.
module tb_bp_skid_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic [7:0] d3, do3;
    logic       v3, r3, rdy3, vo3, f3;
    logic [2:0] cnt3;

    logic [7:0] d2, do2;
    logic       v2, r2, rdy2, vo2, f2;
    logic [2:0] cnt2;

    logic [7:0] d0, do0;
    logic       v0, r0, rdy0, vo0, f0;
    logic [0:0] cnt0;

`ifdef BP_SKID_PIPE_PERF_EN
    logic [31:0] st3, st2, st0;
`endif

    bp_skid_pipe #(.DATAW(8), .PIPES(3)) u3 (
        .clk_i(clk), .rst_i(rst), .flush_i(f3), .data_i(d3), .valid_i(v3), .ready_o(rdy3),
        .data_o(do3), .valid_o(vo3), .ready_i(r3), .count_o(cnt3)
`ifdef BP_SKID_PIPE_PERF_EN
        , .stall_cnt_o(st3)
`endif
    );

    bp_skid_pipe #(.DATAW(8), .PIPES(2)) u2 (
        .clk_i(clk), .rst_i(rst), .flush_i(f2), .data_i(d2), .valid_i(v2), .ready_o(rdy2),
        .data_o(do2), .valid_o(vo2), .ready_i(r2), .count_o(cnt2)
`ifdef BP_SKID_PIPE_PERF_EN
        , .stall_cnt_o(st2)
`endif
    );

    bp_skid_pipe #(.DATAW(8), .PIPES(0)) u0 (
        .clk_i(clk), .rst_i(rst), .flush_i(f0), .data_i(d0), .valid_i(v0), .ready_o(rdy0),
        .data_o(do0), .valid_o(vo0), .ready_i(r0), .count_o(cnt0)
`ifdef BP_SKID_PIPE_PERF_EN
        , .stall_cnt_o(st0)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Hold ready_i low and offer items base, base+1, ... until n are accepted.
    task automatic fill2(input logic [7:0] base, input int n);
        int acc = 0;
        r2 = 1'b0;
        for (int cyc = 0; cyc < 12 && acc < n; cyc++) begin
            v2 = 1'b1;
            d2 = base + 8'(acc);
            @(negedge clk);
            if (rdy2) acc++;
            @(posedge clk); #1;
        end
        v2 = 1'b0;
        check("fill2_accepted", acc, n);
    endtask

    // Push n items from base with ready_i high and require exactly them, in order, at the output.
    task automatic stream2(input string name, input logic [7:0] base, input int n);
        int nxt = 0;
        int got = 0;
        r2 = 1'b1;
        for (int cyc = 0; cyc < n + 10; cyc++) begin
            v2 = (nxt < n);
            d2 = base + 8'(nxt);
            @(negedge clk);
            if (vo2 && r2) begin
                check(name, do2, base + 8'(got));
                got++;
            end
            if (v2 && rdy2) nxt++;
            @(posedge clk); #1;
        end
        v2 = 1'b0;
        check({name, "_count"}, got, n);
    endtask

    typedef struct {
        logic [7:0] d;
        logic       v;
        logic       r;
        logic       f;
        logic [7:0] exp_d;
        logic       exp_v;
        logic       exp_r;
    } pass_vec_t;

    pass_vec_t tbl [6];

    initial begin
        int c0, c1, nxt, got, acc, lastc, rx, cyc;
        logic [7:0] q [$];
        logic [7:0] exp_d, prev_dat;
        logic       prev_stall, took;

        tbl[0] = '{8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[1] = '{8'h5A, 1'b1, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b0};
        tbl[2] = '{8'hA5, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1};
        tbl[3] = '{8'hFF, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b1};
        tbl[4] = '{8'h3C, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b1};
        tbl[5] = '{8'h81, 1'b0, 1'b1, 1'b1, 8'h81, 1'b0, 1'b1};

        rst = 1'b1;
        {d3, v3, r3, f3} = '0;
        {d2, v2, r2, f2} = '0;
        {d0, v0, r0, f0} = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_valid3", vo3, 0);
        check("rst_ready3", rdy3, 1);
        check("rst_data3", do3, 0);
        check("rst_count3", cnt3, 0);
        check("rst_valid2", vo2, 0);
        check("rst_ready2", rdy2, 1);

        // PIPES=3 back-to-back stream of 1..100.
        r3 = 1'b1; nxt = 1; got = 0; c0 = -1; c1 = -1; lastc = 0;
        for (int c = 0; c < 140; c++) begin
            v3 = (nxt <= 100);
            d3 = 8'(nxt);
            @(negedge clk);
            if (v3 && rdy3 && c0 < 0) c0 = c;
            if (vo3) begin
                if (c1 < 0) c1 = c;
                check("t1_data", do3, 32'(1 + c - c1));
                got++;
                lastc = c;
            end
            if (v3 && rdy3 && vo3) check("t1_count", cnt3, 3);
            if (v3 && rdy3) nxt++;
            @(posedge clk); #1;
        end
        v3 = 1'b0;
        check("t1_latency", c1 - c0, 3);
        check("t1_items", got, 100);
        check("t1_no_bubble", lastc - c1, 99);

        // PIPES=2 fill against a stalled consumer, then drain.
        r2 = 1'b0; acc = 0;
        for (int c = 0; c < 10; c++) begin
            v2 = 1'b1;
            d2 = 8'hA0 + 8'(acc);
            @(negedge clk);
            if (rdy2) acc++;
            @(posedge clk); #1;
        end
        v2 = 1'b0;
        @(negedge clk);
        check("t2_accepted", acc, 4);
        check("t2_ready_low", rdy2, 0);
        check("t2_count", cnt2, 4);
        check("t2_head", do2, 8'hA0);
        @(posedge clk); #1;
        r2 = 1'b1; got = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (vo2) begin
                check("t2_drain", do2, 8'hA0 + 8'(got));
                got++;
            end
            @(posedge clk); #1;
        end
        check("t2_drained", got, 4);

        // Flush with three held and an item offered in the flush cycle.
        fill2(8'h30, 3);
        @(negedge clk);
        check("t3_count_before", cnt2, 3);
        check("t3_ready_before", rdy2, 1);
        @(posedge clk); #1;
        f2 = 1'b1; v2 = 1'b1; d2 = 8'hEE;
        @(posedge clk); #1;
        f2 = 1'b0; v2 = 1'b0;
        @(negedge clk);
        check("t3_valid_after", vo2, 0);
        check("t3_count_after", cnt2, 0);
        check("t3_ready_after", rdy2, 1);
        @(posedge clk); #1;
        stream2("t3_out", 8'h55, 2);

        // Reset mid-stream with four held.
        fill2(8'h60, 4);
        @(negedge clk);
        check("t4_count_before", cnt2, 4);
        @(posedge clk); #1;
        rst = 1'b1; v2 = 1'b1; d2 = 8'h77;
        @(posedge clk); #1;
        rst = 1'b0; v2 = 1'b0;
        check("t4_valid", vo2, 0);
        check("t4_ready", rdy2, 1);
        check("t4_data", do2, 0);
        check("t4_count", cnt2, 0);
        stream2("t4_restart", 8'h10, 3);

`ifdef BP_SKID_PIPE_PERF_EN
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("perf_reset", st0, 0);
        v0 = 1'b1; r0 = 1'b0;
        repeat (7) @(posedge clk);
        #1 v0 = 1'b0;
        check("perf_stall7", st0, 7);
        @(posedge clk); #1;
        check("perf_hold", st0, 7);
`endif

        // PIPES=0 pass-through vectors; flush must have no effect.
        for (int i = 0; i < 6; i++) begin
            d0 = tbl[i].d; v0 = tbl[i].v; r0 = tbl[i].r; f0 = tbl[i].f;
            #1;
            check("p0_data", do0, tbl[i].exp_d);
            check("p0_valid", vo0, tbl[i].exp_v);
            check("p0_ready", rdy0, tbl[i].exp_r);
            check("p0_count", cnt0, 0);
        end
        {d0, v0, r0, f0} = '0;
        @(posedge clk); #1;

        // Random valid/ready on PIPES=3 against a queue model.
        rx = 0; cyc = 0; prev_stall = 1'b0; prev_dat = '0; took = 1'b0;
        v3 = 1'b0;
        while (rx < 10000 && cyc < 60000) begin
            r3 = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (prev_stall) begin
                check("rnd_stable_valid", vo3, 1);
                check("rnd_stable_data", do3, prev_dat);
            end
            check("rnd_count", cnt3, q.size());
            if (vo3 && r3) begin
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rnd_spurious: output 0x%0h with empty model", do3);
                end else begin
                    exp_d = q.pop_front();
                    check("rnd_data", do3, exp_d);
                end
                rx++;
            end
            took = v3 && rdy3;
            if (took) q.push_back(d3);
            prev_stall = vo3 && !r3;
            prev_dat = do3;
            @(posedge clk); #1;
            cyc++;
            if (!v3 || took) begin
                v3 = 1'($urandom_range(0, 1));
                d3 = 8'($urandom);
            end
        end
        check("rnd_items", rx, 10000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
